// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen_pkg
// Purpose  : Shared defines for the fetch-address generator.
// Revision : 1.0 - initial release
// ============================================================================
package pc_gen_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic JumpEnable  = 1'b1;
    localparam logic Stop        = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    localparam int StallBus = 6;

    typedef enum logic [0:0] {
        PC_BOOT = 1'b0,
        PC_RUN  = 1'b1
    } pc_state_e;

endpackage
`default_nettype wire

// File: rtl/pc_redirect_buf.sv
`default_nettype none
// ============================================================================
// Module   : pc_redirect_buf
// Purpose  : Holds one branch target that arrived while a fetch was stalled
//            on the ROM handshake. A newer load overwrites the held target.
// Revision : 1.0 - initial release
// ============================================================================
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] load_addr,
    output logic              pend,
    output logic [ADDR_W-1:0] pend_addr
);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pend      <= 1'b0;
            pend_addr <= '0;
        end else if (load) begin
            pend      <= 1'b1;
            pend_addr <= load_addr;
        end else if (clear) begin
            pend      <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Purpose  : Program-counter / fetch-address generator with valid/ready
//            handshake, buffered redirect and priority flush.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                PC_STEP   = 1,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                STALL_W   = StallBus
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  flush_addr_i,
    input  logic               fetch_ready_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               fetch_valid_o,
    output logic               redirect_pend_o
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    pc_state_e         state;
    logic [ADDR_W-1:0] pc;
    logic              valid;
    logic              freeze;
    logic              take_branch;
    logic              fire;
    logic              outstanding;
    logic              pend;
    logic [ADDR_W-1:0] pend_addr;
    logic              buf_load;
    logic              buf_clear;
    logic              unused_stall;

    // Only bit 0 of the stall bus concerns the PC.
    assign unused_stall = ^stall_i;

    assign freeze      = (stall_i[0] == Stop);
    assign take_branch = (branch_flag_i == JumpEnable);
    assign fire        = valid & fetch_ready_i & ~freeze;
    assign outstanding = valid & ~fetch_ready_i;

    // A branch can only be taken directly when no request is awaiting the ROM.
    assign buf_load  = ~flush_i & take_branch & outstanding;
    assign buf_clear = flush_i | (take_branch & ~outstanding) | (fire & pend);

    pc_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_redirect_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_addr (branch_target_i),
        .pend      (pend),
        .pend_addr (pend_addr)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state <= PC_BOOT;
            valid <= ChipDisable;
            pc    <= RESET_VEC;
        end else begin
            case (state)
                PC_BOOT: begin
                    state <= PC_RUN;
                    valid <= ChipDisable;
                end
                default: begin
                    state <= PC_RUN;
                    valid <= ChipEnable;
                end
            endcase

            if (flush_i) begin
                pc <= flush_addr_i;
            end else if (take_branch && !outstanding) begin
                pc <= branch_target_i;
            end else if (fire && pend) begin
                pc <= pend_addr;
            end else if (fire) begin
                pc <= pc + STEP;
            end
        end
    end

    assign pc_o            = pc;
    assign fetch_valid_o   = valid;
    assign redirect_pend_o = pend;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Purpose  : Directed and randomized checks of pc_gen against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    localparam logic [15:0] RV = 16'h0100;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [5:0]  stall;
    logic        branch;
    logic [15:0] target;
    logic        flush;
    logic [15:0] faddr;
    logic        ready;
    logic [15:0] pc;
    logic        valid;
    logic        pend;

    logic        rst2;
    logic [5:0]  stall2;
    logic        branch2;
    logic [7:0]  target2;
    logic        flush2;
    logic [7:0]  faddr2;
    logic        ready2;
    logic [7:0]  pc2;
    logic        valid2;
    logic        pend2;

    pc_gen #(.ADDR_W(16), .PC_STEP(1), .RESET_VEC(RV), .STALL_W(6)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(branch),
        .branch_target_i(target), .flush_i(flush), .flush_addr_i(faddr),
        .fetch_ready_i(ready), .pc_o(pc), .fetch_valid_o(valid),
        .redirect_pend_o(pend)
    );

    pc_gen #(.ADDR_W(8), .PC_STEP(4), .RESET_VEC(8'hF8), .STALL_W(6)) dut_wrap (
        .clk(clk), .rst(rst2), .stall_i(stall2), .branch_flag_i(branch2),
        .branch_target_i(target2), .flush_i(flush2), .flush_addr_i(faddr2),
        .fetch_ready_i(ready2), .pc_o(pc2), .fetch_valid_o(valid2),
        .redirect_pend_o(pend2)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: architectural view of the fetch unit.
    logic [15:0] m_pc = '0;
    logic [15:0] m_paddr = '0;
    logic        m_valid = 1'b0;
    logic        m_pend = 1'b0;
    logic        m_live = 1'b0;

    task automatic model_step();
        logic f, o;
        if (rst) begin
            m_pc = RV; m_valid = 1'b0; m_pend = 1'b0; m_live = 1'b0;
        end else begin
            f = m_valid & ready & ~stall[0];
            o = m_valid & ~ready;
            if (flush) begin
                m_pc = faddr; m_pend = 1'b0;
            end else if (branch && !o) begin
                m_pc = target; m_pend = 1'b0;
            end else if (branch) begin
                m_pend = 1'b1; m_paddr = target;
            end else if (f && m_pend) begin
                m_pc = m_paddr; m_pend = 1'b0;
            end else if (f) begin
                m_pc = m_pc + 16'd1;
            end
            m_valid = m_live;
            m_live  = 1'b1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = '0; branch = 1'b0; target = '0; flush = 1'b0; faddr = '0; ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_inputs();
        repeat (3) tick();
        vectors++; if (pc !== RV) begin miscompares++; $display("FAIL reset_pc: got %h want %h", pc, RV); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid); end
        vectors++; if (pend !== 1'b0) begin miscompares++; $display("FAIL reset_pend: got %b want 0", pend); end
        rst = 1'b0;
        tick();
        vectors++; if (valid !== 1'b0 || pc !== RV) begin miscompares++; $display("FAIL boot_cycle: got valid=%b pc=%h want valid=0 pc=%h", valid, pc, RV); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (valid !== 1'b1 || pc !== RV + 16'(i)) begin
                miscompares++; $display("FAIL boot_seq%0d: got valid=%b pc=%h want valid=1 pc=%h", i, valid, pc, RV + 16'(i));
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'hF8; exp_seq[1] = 8'hFC; exp_seq[2] = 8'h00; exp_seq[3] = 8'h04;
        rst2 = 1'b1;
        repeat (2) tick();
        rst2 = 1'b0;
        tick();
        vectors++; if (valid2 !== 1'b0) begin miscompares++; $display("FAIL wrap_boot_valid: got %b want 0", valid2); end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (valid2 !== 1'b1 || pc2 !== exp_seq[i]) begin
                miscompares++; $display("FAIL wrap_seq%0d: got valid=%b pc=%h want valid=1 pc=%h", i, valid2, pc2, exp_seq[i]);
            end
        end
    endtask

    task automatic test_stall_branch();
        logic [15:0] held;
        held = pc;
        stall = 6'b111011;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (pc !== held) begin miscompares++; $display("FAIL stall_hold%0d: got %h want %h", i, pc, held); end
        end
        branch = 1'b1; target = 16'h0040;
        tick();
        branch = 1'b0;
        vectors++; if (pc !== 16'h0040) begin miscompares++; $display("FAIL stall_branch: got %h want 0040", pc); end
        tick();
        vectors++; if (pc !== 16'h0040) begin miscompares++; $display("FAIL stall_branch_hold: got %h want 0040", pc); end
        stall = 6'b111110;
        tick();
        vectors++; if (pc !== 16'h0041) begin miscompares++; $display("FAIL stall_release: got %h want 0041", pc); end
        stall = '0;
    endtask

    task automatic test_pending();
        branch = 1'b1; target = 16'h0010;
        tick();
        vectors++; if (pc !== 16'h0010) begin miscompares++; $display("FAIL pend_setup: got %h want 0010", pc); end
        ready = 1'b0; target = 16'h0080;
        tick();
        branch = 1'b0;
        vectors++; if (pc !== 16'h0010 || pend !== 1'b1) begin miscompares++; $display("FAIL pend_latch: got pc=%h pend=%b want pc=0010 pend=1", pc, pend); end
        tick();
        vectors++; if (pc !== 16'h0010 || pend !== 1'b1) begin miscompares++; $display("FAIL pend_hold: got pc=%h pend=%b want pc=0010 pend=1", pc, pend); end
        ready = 1'b1;
        tick();
        vectors++; if (pc !== 16'h0080 || pend !== 1'b0) begin miscompares++; $display("FAIL pend_apply: got pc=%h pend=%b want pc=0080 pend=0", pc, pend); end
        tick();
        vectors++; if (pc !== 16'h0081) begin miscompares++; $display("FAIL pend_next: got %h want 0081", pc); end
    endtask

    task automatic test_flush();
        ready = 1'b0; branch = 1'b1; target = 16'h0080;
        tick();
        branch = 1'b0;
        vectors++; if (pend !== 1'b1) begin miscompares++; $display("FAIL flush_setup_pend: got %b want 1", pend); end
        flush = 1'b1; faddr = 16'h0200;
        tick();
        flush = 1'b0;
        vectors++; if (pc !== 16'h0200 || pend !== 1'b0) begin miscompares++; $display("FAIL flush_pending: got pc=%h pend=%b want pc=0200 pend=0", pc, pend); end
        ready = 1'b1; flush = 1'b1; faddr = 16'h0200; branch = 1'b1; target = 16'h0300;
        tick();
        flush = 1'b0; branch = 1'b0;
        vectors++; if (pc !== 16'h0200) begin miscompares++; $display("FAIL flush_vs_branch: got %h want 0200", pc); end
        tick();
        vectors++; if (pc !== 16'h0201 || pend !== 1'b0) begin miscompares++; $display("FAIL flush_next: got pc=%h pend=%b want pc=0201 pend=0", pc, pend); end
    endtask

    task automatic test_reset_mid();
        ready = 1'b0; branch = 1'b1; target = 16'h0080;
        tick();
        branch = 1'b0; rst = 1'b1;
        tick();
        vectors++; if (pc !== RV || valid !== 1'b0 || pend !== 1'b0) begin miscompares++; $display("FAIL reset_mid: got pc=%h valid=%b pend=%b want pc=%h valid=0 pend=0", pc, valid, pend, RV); end
        rst = 1'b0;
        tick();
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_mid_boot: got valid=%b want 0", valid); end
        tick();
        vectors++; if (valid !== 1'b1 || pc !== RV) begin miscompares++; $display("FAIL reset_mid_first: got valid=%b pc=%h want valid=1 pc=%h", valid, pc, RV); end
        ready = 1'b1;
        tick();
        vectors++; if (pc !== RV + 16'd1 || pend !== 1'b0) begin miscompares++; $display("FAIL reset_mid_next: got pc=%h pend=%b want pc=%h pend=0", pc, pend, RV + 16'd1); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 63) == 0);
            stall  = 6'($urandom);
            stall[0] = ($urandom_range(0, 9) < 3);
            ready  = ($urandom_range(0, 9) < 7);
            branch = ($urandom_range(0, 99) < 15);
            flush  = ($urandom_range(0, 99) < 5);
            target = 16'($urandom);
            faddr  = 16'($urandom);
            tick();
            vectors++;
            if (pc !== m_pc || valid !== m_valid || pend !== m_pend) begin
                miscompares++;
                $display("FAIL random%0d: got pc=%h valid=%b pend=%b want pc=%h valid=%b pend=%b",
                         i, pc, valid, pend, m_pc, m_valid, m_pend);
            end
        end
        rst = 1'b0; idle_inputs();
    endtask

    initial begin
        rst = 1'b1; idle_inputs();
        rst2 = 1'b1; stall2 = '0; branch2 = 1'b0; target2 = '0;
        flush2 = 1'b0; faddr2 = '0; ready2 = 1'b1;
        test_reset();
        test_wrap();
        test_stall_branch();
        test_pending();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
